// File: rtl/enc_pkg.sv
// enc_pkg: shared ENC28J60 command types and field widths for the command arbiter.
`default_nettype none

package enc_pkg;

  localparam int ENC_OPC_W  = 3;
  localparam int ENC_ADDR_W = 5;
  localparam int ENC_DATA_W = 8;

  typedef enum logic [ENC_OPC_W-1:0] {
    RCR = 3'd0,
    RBM = 3'd1,
    WCR = 3'd2,
    WBM = 3'd3,
    BFS = 3'd4,
    BFC = 3'd5,
    SRC = 3'd7
  } enc_opcode_e;

  typedef struct packed {
    enc_opcode_e             opcode;
    logic [ENC_ADDR_W-1:0]   addr;
    logic [ENC_DATA_W-1:0]   data;
  } enc_cmd_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/enc_rr_pick.sv
// enc_rr_pick: combinational round-robin selector; scans from rr_ptr+1 and wraps.
`default_nettype none

module enc_rr_pick #(
  parameter int N_REQ = 3,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx,
  output logic             valid
);

  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(rr_ptr) + k) % N_REQ);
      if (!valid && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        valid       = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/enc_cmd_arbiter.sv
// enc_cmd_arbiter: round-robin sharing of the enc_driver SPI command engine.
// Optional WAIT timeout abort is enabled by defining ENC_ARB_TIMEOUT_EN.
`default_nettype none

module enc_cmd_arbiter
  import enc_pkg::*;
#(
  parameter int N_REQ          = 3,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*ENC_OPC_W-1:0]  req_opcode,
  input  logic [N_REQ*ENC_ADDR_W-1:0] req_addr,
  input  logic [N_REQ*ENC_DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            done,
  output logic                        err,
  output logic                        busy,
  output logic                        run_req,
  input  logic                        end_flag,
  output logic [ENC_OPC_W-1:0]        opcode,
  output logic [ENC_ADDR_W-1:0]       write_addr,
  output logic [ENC_DATA_W-1:0]       write_data
);

  localparam int IW = $clog2(N_REQ);

  arb_state_e       state, state_nxt;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    pick_idx;
  logic [N_REQ-1:0] pick_gnt;
  logic             pick_valid;
  logic             end_ok;
  logic             tmo_hit;
  enc_cmd_t         cmd_in [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign cmd_in[i] = {req_opcode[ENC_OPC_W*i +: ENC_OPC_W],
                        req_addr[ENC_ADDR_W*i +: ENC_ADDR_W],
                        req_data[ENC_DATA_W*i +: ENC_DATA_W]};
  end

  enc_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .grant  (pick_gnt),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  // run_req is registered, so it is high in the first WAIT cycle; end_flag is not trusted there.
  assign end_ok = (state == S_WAIT) && end_flag && !run_req;
  assign busy   = (state != S_IDLE);

`ifdef ENC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != S_WAIT) wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + 1'b1;
  end

  assign tmo_hit = (state == S_WAIT) && !end_ok && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (pick_valid)        state_nxt = S_ISSUE;
      S_ISSUE:                        state_nxt = S_WAIT;
      S_WAIT:  if (end_ok || tmo_hit) state_nxt = S_DONE;
      S_DONE:                         state_nxt = S_IDLE;
      default:                        state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rr_ptr     <= IW'(N_REQ - 1);
      win_idx    <= '0;
      gnt        <= '0;
      done       <= '0;
      err        <= 1'b0;
      run_req    <= 1'b0;
      opcode     <= '0;
      write_addr <= '0;
      write_data <= '0;
    end else begin
      state   <= state_nxt;
      run_req <= (state == S_ISSUE);
      done    <= '0;
      err     <= 1'b0;
      case (state)
        S_IDLE: if (pick_valid) begin
          gnt        <= pick_gnt;
          win_idx    <= pick_idx;
          opcode     <= cmd_in[pick_idx].opcode;
          write_addr <= cmd_in[pick_idx].addr;
          write_data <= cmd_in[pick_idx].data;
        end
        S_WAIT: if (end_ok || tmo_hit) begin
          done <= gnt;
          err  <= tmo_hit;
        end
        S_DONE: begin
          gnt    <= '0;
          rr_ptr <= win_idx;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_enc_cmd_arbiter.sv
// tb_enc_cmd_arbiter: table-driven round-robin vectors plus directed corner-case sequences.
`default_nettype none

module tb_enc_cmd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [8:0]  req_opcode;
  logic [14:0] req_addr;
  logic [23:0] req_data;
  logic [2:0]  gnt, done;
  logic        err, busy, run_req, end_flag;
  logic [2:0]  opcode;
  logic [4:0]  write_addr;
  logic [7:0]  write_data;

  int errors = 0;
  int checks = 0;

  enc_cmd_arbiter #(.N_REQ(3), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_opcode (req_opcode),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .gnt        (gnt),
    .done       (done),
    .err        (err),
    .busy       (busy),
    .run_req    (run_req),
    .end_flag   (end_flag),
    .opcode     (opcode),
    .write_addr (write_addr),
    .write_data (write_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] req;
    logic [2:0] gnt;
    logic [2:0] opc;
    logic [4:0] addr;
    logic [7:0] data;
    int         lat;
    int         dly;
  } vec_t;

  vec_t tbl [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_run(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!run_req && n < 40);
    check("run_req_seen", {31'd0, run_req}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int  n;
    bit  early;
    req = v.req;
    wait_run(n);
    check($sformatf("v%0d_latency", id), n, v.lat);
    check($sformatf("v%0d_gnt", id), {29'd0, gnt}, {29'd0, v.gnt});
    check($sformatf("v%0d_fields", id), {16'd0, opcode, write_addr, write_data},
          {16'd0, v.opc, v.addr, v.data});
    early = 1'b0;
    repeat (v.dly - 1) begin
      tick();
      if (done !== 3'b000 || busy !== 1'b1) early = 1'b1;
    end
    check($sformatf("v%0d_wait_quiet", id), {31'd0, early}, 32'd0);
    end_flag = 1'b1;
    tick();
    end_flag = 1'b0;
    check($sformatf("v%0d_done", id), {28'd0, done, err}, {28'd0, v.gnt, 1'b0});
  endtask

  initial begin
    int  n;
    bit  early;

    tbl[0] = '{3'b111, 3'b001, 3'd2, 5'h1F, 8'h00, 2, 10};
    tbl[1] = '{3'b111, 3'b010, 3'd0, 5'h05, 8'hA5, 3, 10};
    tbl[2] = '{3'b111, 3'b100, 3'd4, 5'h0A, 8'h3C, 3, 10};
    tbl[3] = '{3'b111, 3'b001, 3'd2, 5'h1F, 8'h00, 3, 10};
    tbl[4] = '{3'b101, 3'b100, 3'd4, 5'h0A, 8'h3C, 3, 4};
    tbl[5] = '{3'b010, 3'b010, 3'd0, 5'h05, 8'hA5, 3, 2};
    tbl[6] = '{3'b011, 3'b001, 3'd2, 5'h1F, 8'h00, 3, 6};
    tbl[7] = '{3'b110, 3'b010, 3'd0, 5'h05, 8'hA5, 3, 3};

    rst        = 1'b1;
    req        = 3'b111;
    end_flag   = 1'b0;
    req_opcode = {3'd4, 3'd0, 3'd2};
    req_addr   = {5'h0A, 5'h05, 5'h1F};
    req_data   = {8'h3C, 8'hA5, 8'h00};

    repeat (3) begin
      tick();
      check("reset_outputs",
            {7'd0, gnt, done, err, busy, run_req, opcode, write_addr, write_data}, 32'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

    req = 3'b000;
    tick();
    tick();
    check("idle_after_table", {28'd0, busy, gnt}, 32'd0);

    // Latched data must not follow the requester once granted.
    req = 3'b010;
    wait_run(n);
    check("stab_latched", {24'd0, write_data}, 32'hA5);
    req_data[15:8] = 8'h5A;
    repeat (4) tick();
    check("stab_in_wait", {24'd0, write_data}, 32'hA5);
    end_flag = 1'b1;
    tick();
    end_flag = 1'b0;
    check("stab_done", {21'd0, done, write_data}, {21'd0, 3'b010, 8'hA5});
    req            = 3'b000;
    req_data[15:8] = 8'hA5;
    tick();
    tick();

    // Spurious end_flag in IDLE, in ISSUE and in the run_req cycle.
    end_flag = 1'b1;
    tick();
    end_flag = 1'b0;
    check("spur_idle", {28'd0, done, busy}, 32'd0);
    req = 3'b001;
    tick();
    check("spur_issue_state", {30'd0, busy, run_req}, 32'd2);
    end_flag = 1'b1;
    tick();
    check("spur_run_req", {31'd0, run_req}, 32'd1);
    tick();
    end_flag = 1'b0;
    check("spur_no_done", {29'd0, done}, 32'd0);
    repeat (3) tick();
    check("spur_still_wait", {28'd0, done, busy}, 32'd1);
    end_flag = 1'b1;
    tick();
    end_flag = 1'b0;
    check("spur_real_done", {29'd0, done}, 32'd1);
    req = 3'b000;
    tick();
    tick();

    // Reset during WAIT abandons the command.
    req = 3'b100;
    wait_run(n);
    tick();
    tick();
    req = 3'b000;
    rst = 1'b1;
    tick();
    check("rst_wait_outputs", {25'd0, busy, gnt, done, run_req}, 32'd0);
    rst = 1'b0;
    tick();
    end_flag = 1'b1;
    tick();
    end_flag = 1'b0;
    check("rst_late_end_flag", {28'd0, done, busy}, 32'd0);

    req = 3'b001;
    wait_run(n);
`ifdef ENC_ARB_TIMEOUT_EN
    early = 1'b0;
    repeat (15) begin
      tick();
      if (done !== 3'b000) early = 1'b1;
    end
    check("tmo_not_early", {31'd0, early}, 32'd0);
    tick();
    check("tmo_done_err", {28'd0, done, err}, {28'd0, 3'b001, 1'b1});
    req = 3'b000;
    tick();
    tick();
    check("tmo_back_idle", {31'd0, busy}, 32'd0);
`else
    early = 1'b0;
    repeat (30) begin
      tick();
      if (done !== 3'b000 || err !== 1'b0) early = 1'b1;
    end
    check("no_tmo_quiet", {31'd0, early}, 32'd0);
    check("no_tmo_busy", {31'd0, busy}, 32'd1);
    req = 3'b000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
